ps2_host_cmd_rx: RTL

- Device-side PS/2 receiver for host-to-device command frames, such as 0xED (set LEDs), 0xF3 (typematic), 0xFF (reset) and argument bytes.
- Detects the host request-to-send (RTS), generates the device clock, and samples 8 data bits, odd parity and the stop bit. It then drives the ack bit.
- Sits beside keyboard_ps2 (device-to-host transmitter) on the shared PS2_CLK/PS2_DAT lines. Delivers command bytes to the keyboard command handler.
- Open-drain pins are driven through output-enable (OE) outputs; the top level builds the tri-state buffers.

---
 rtl/ps2_host_cmd_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_cmd_rx.sv
// PS/2 device-side receiver for host-to-device command frames.
// Detects host RTS, clocks in 8 data bits, parity and stop, then acks.
module ps2_host_cmd_rx #(
  parameter int HALF_PERIOD = 2000,
  parameter int RTS_MIN     = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_active,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int CMAX = (RTS_MIN > HALF_PERIOD) ? RTS_MIN : HALF_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] RTS_CNT = CW'(RTS_MIN);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, CLK_LOW, CLK_HIGH, ACK_LOW, ACK_HIGH
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bi, bi_n;
  logic [7:0] sr, sr_n;
  logic par, par_n;
  logic lead, lead_n;
  logic [7:0] data_n;
  logic valid_n, error_n;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_s, dat_s;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Sync flops idle high so reset never looks like a host hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bi       <= '0;
      sr       <= '0;
      par      <= 1'b0;
      lead     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bi       <= bi_n;
      sr       <= sr_n;
      par      <= par_n;
      lead     <= lead_n;
      rx_data  <= data_n;
      rx_valid <= valid_n;
      rx_error <= error_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bi_n    = bi;
    sr_n    = sr;
    par_n   = par;
    lead_n  = lead;
    data_n  = rx_data;
    valid_n = 1'b0;
    error_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (clk_s) begin
          cnt_n = '0;
        end else if (cnt == RTS_CNT) begin
          if (!tx_active) begin
            state_n = INHIBIT;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      INHIBIT: begin
        if (clk_s) begin
          cnt_n = '0;
          if (!dat_s) begin
            state_n = CLK_HIGH;
            bi_n    = '0;
            lead_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      CLK_LOW: begin
        cnt_n = cnt + CW'(1);
        if (cnt == HP_LAST) begin
          cnt_n   = '0;
          state_n = CLK_HIGH;
        end
      end
      CLK_HIGH: begin
        cnt_n = cnt + CW'(1);
        if (cnt == HP_LAST) begin
          cnt_n   = '0;
          state_n = CLK_LOW;
          if (!clk_s) begin
            state_n = IDLE;
          end else if (lead) begin
            lead_n = 1'b0;
          end else begin
            bi_n = bi + 4'd1;
            unique case (1'b1)
              (bi < 4'd8): sr_n = {dat_s, sr[7:1]};
              (bi == 4'd8): par_n = dat_s;
              default: begin
                if (dat_s && (^{sr, par})) begin
                  state_n = ACK_LOW;
                end else begin
                  state_n = IDLE;
                  error_n = 1'b1;
                end
              end
            endcase
          end
        end
      end
      ACK_LOW: begin
        cnt_n = cnt + CW'(1);
        if (cnt == HP_LAST) begin
          cnt_n   = '0;
          state_n = ACK_HIGH;
        end
      end
      ACK_HIGH: begin
        cnt_n = cnt + CW'(1);
        if (cnt == HP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          data_n  = sr;
          valid_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Gated by reset so the bus is released in the reset cycle itself.
  assign ps2_clk_oe = !reset &&
    (state == CLK_LOW || state == ACK_LOW);
  assign ps2_dat_oe = !reset &&
    (state == ACK_LOW || state == ACK_HIGH);
  assign busy = !reset &&
    !(state == IDLE || state == INHIBIT);

endmodule
